// File: rtl/lap_timer.sv
// -----------------------------------------------------------------------------
// lap_timer
//
// Race-control stage that sits behind the checkpoint tracker. It qualifies
// laps (a rising edge of lap_finished while checkpoints_passed is high),
// counts them, times the current lap and the whole race in centiseconds,
// keeps the last and best lap times, and declares the race over after LAPS
// valid laps.
//
// Parameters
//   CLK_HZ : pclk frequency in Hz; one centisecond = CLK_HZ/100 cycles.
//   LAPS   : valid laps needed to finish the race (1..15).
//
// Ports
//   pclk               in   clock, everything updates on its rising edge
//   rst                in   synchronous active-high reset
//   start              in   1-cycle pulse: start / restart the race
//   lap_finished       in   level: car is inside the finish zone
//   checkpoints_passed in   level: all checkpoints of this lap were taken
//   lap_count          out  [3:0]  valid laps completed this race
//   lap_time_cs        out  [15:0] running time of the current lap
//   last_lap_cs        out  [15:0] time of the most recent valid lap
//   best_lap_cs        out  [15:0] fastest valid lap this race
//   best_valid         out         best_lap_cs holds a real value
//   total_time_cs      out  [19:0] race time since start
//   new_lap            out         1-cycle pulse per valid lap
//   new_best           out         1-cycle pulse with new_lap on a new best
//   race_over          out         high once LAPS valid laps are done
// -----------------------------------------------------------------------------
module lap_timer #(
  parameter int CLK_HZ = 65_000_000,
  parameter int LAPS   = 3
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic        lap_finished,
  input  logic        checkpoints_passed,
  output logic [3:0]  lap_count,
  output logic [15:0] lap_time_cs,
  output logic [15:0] last_lap_cs,
  output logic [15:0] best_lap_cs,
  output logic        best_valid,
  output logic [19:0] total_time_cs,
  output logic        new_lap,
  output logic        new_best,
  output logic        race_over
);

  // Centisecond prescaler geometry. A divisor below 1 would make no sense,
  // so very slow clocks degrade to one tick per cycle.
  localparam int TICK_DIV  = (CLK_HZ / 100 < 1) ? 1 : CLK_HZ / 100;
  localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [4:0]    LAPS_W    = 5'(LAPS);

  localparam logic [15:0] LAP_SAT   = 16'hFFFF;
  localparam logic [19:0] TOTAL_SAT = 20'hFFFFF;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RACING   = 2'd1,
    S_FINISHED = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          lap_finished_d;

  // Decoded events for the current cycle.
  logic fin_rise;
  logic valid_lap;
  logic tick;
  logic lap_improves;
  logic last_lap_of_race;

  // NOTE: every signal written here gets a value on every path (defaults
  // first), so this stays purely combinational and never infers a latch.
  always_comb begin
    fin_rise         = 1'b0;
    valid_lap        = 1'b0;
    tick             = 1'b0;
    lap_improves     = 1'b0;
    last_lap_of_race = 1'b0;

    fin_rise  = lap_finished & ~lap_finished_d;
    // Upstream clears the checkpoint flags only after it has registered the
    // finish, so checkpoints_passed is still meaningful on the rise cycle.
    valid_lap = fin_rise & checkpoints_passed;
    tick      = (state == S_RACING) && (presc == PRESC_MAX);
    // A tie does not count as an improvement.
    lap_improves     = !best_valid || (lap_time_cs < best_lap_cs);
    last_lap_of_race = (({1'b0, lap_count} + 5'd1) == LAPS_W);
  end

  // NOTE: all state below is registered with non-blocking assignments so that
  // every right-hand side reads the pre-edge value (e.g. last_lap_cs captures
  // the lap time before this cycle's tick would have been added).
  always_ff @(posedge pclk) begin
    if (rst) begin
      state          <= S_IDLE;
      presc          <= '0;
      lap_finished_d <= 1'b0;
      lap_count      <= '0;
      lap_time_cs    <= '0;
      last_lap_cs    <= '0;
      best_lap_cs    <= '0;
      best_valid     <= 1'b0;
      total_time_cs  <= '0;
      new_lap        <= 1'b0;
      new_best       <= 1'b0;
      race_over      <= 1'b0;
    end else begin
      // Edge detector history runs in every state so a car parked in the
      // finish zone at start does not produce a spurious rise later.
      lap_finished_d <= lap_finished;

      // Event pulses last exactly one cycle unless re-asserted below.
      new_lap  <= 1'b0;
      new_best <= 1'b0;

      if (start) begin
        // Start (or restart) from any state; it wins over a coincident lap.
        state         <= S_RACING;
        presc         <= '0;
        lap_count     <= '0;
        lap_time_cs   <= '0;
        last_lap_cs   <= '0;
        best_lap_cs   <= '0;
        best_valid    <= 1'b0;
        total_time_cs <= '0;
        race_over     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // Timers and prescaler hold until the countdown fires start.
          end

          S_RACING: begin
            // The prescaler free-runs across laps; a lap never resets it.
            if (tick) begin
              presc <= '0;
            end else begin
              presc <= presc + PW'(1);
            end

            if (tick && (total_time_cs != TOTAL_SAT)) begin
              total_time_cs <= total_time_cs + 20'd1;
            end

            if (valid_lap) begin
              // The lap time is captured without this cycle's tick, and the
              // new lap starts from zero.
              last_lap_cs <= lap_time_cs;
              lap_time_cs <= '0;
              lap_count   <= lap_count + 4'd1;
              new_lap     <= 1'b1;

              if (lap_improves) begin
                best_lap_cs <= lap_time_cs;
                best_valid  <= 1'b1;
                new_best    <= 1'b1;
              end

              if (last_lap_of_race) begin
                state     <= S_FINISHED;
                race_over <= 1'b1;
              end
            end else if (tick && (lap_time_cs != LAP_SAT)) begin
              lap_time_cs <= lap_time_cs + 16'd1;
            end
          end

          S_FINISHED: begin
            // Everything frozen; finish-zone activity is ignored.
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/lap_timer.md
# lap_timer

Race-control stage directly downstream of the checkpoint tracker. Consumes its registered `lap_finished` and `checkpoints_passed` flags, qualifies valid laps, and counts them. Times the current lap and the whole race in centiseconds, and keeps the last and best lap times. Declares the race over after `LAPS` valid laps. Outputs feed the HUD/text renderer and the game-state controller.

## Interface
Parameters:
- `CLK_HZ`, default 65_000_000: pclk frequency; centisecond tick period = CLK_HZ/100 cycles (integer division).
- `LAPS`, default 3: valid laps to finish the race, range 1..15.

Ports:
- `pclk` input 1: pixel clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle pulse from the countdown block; starts or restarts the race.
- `lap_finished` input 1: level flag, high while the car is inside the finish zone.
- `checkpoints_passed` input 1: level flag, high when all six checkpoints are set.
- `lap_count` output 4: valid laps completed in the current race.
- `lap_time_cs` output 16: running time of the current lap in centiseconds.
- `last_lap_cs` output 16: time of the most recently completed valid lap.
- `best_lap_cs` output 16: fastest valid lap this race.
- `best_valid` output 1: `best_lap_cs` holds a real value.
- `total_time_cs` output 20: race time since `start`.
- `new_lap` output 1: one-cycle pulse per valid lap.
- `new_best` output 1: one-cycle pulse, coincident with `new_lap`, when the lap improved the best time.
- `race_over` output 1: high in FINISHED.

## Operation
- Reset: state IDLE. All outputs 0. Prescaler 0. Internal `lap_finished_d` 0.
- `lap_finished_d` is a 1-cycle delayed copy of `lap_finished`. Rise event `fin_rise = lap_finished & ~lap_finished_d`.
- `valid_lap = fin_rise & checkpoints_passed`, sampled in the same cycle as the rise. The upstream block clears checkpoints only after `lap_finished` is registered, so the flag is still valid on that cycle.
- A rise with `checkpoints_passed = 0` is ignored. This covers start-grid position and shortcuts.
- State IDLE:
  - Timers and prescaler are held.
  - `start` moves to RACING and clears `lap_count`, `lap_time_cs`, `last_lap_cs`, `best_lap_cs`, `best_valid`, `total_time_cs` and the prescaler.
- State RACING:
  - The prescaler counts 0..CLK_HZ/100-1. At wrap a tick is generated.
  - On a tick, `lap_time_cs` and `total_time_cs` each increment and saturate at all-ones (16'hFFFF and 20'hFFFFF respectively).
  - On `valid_lap`:
    - `last_lap_cs` takes the current `lap_time_cs`; the tick in the same cycle is not included.
    - `lap_time_cs` is set to 0 and `lap_count` increments.
    - `new_lap` is asserted.
    - If `!best_valid` or `lap_time_cs < best_lap_cs`: `best_lap_cs` takes `lap_time_cs`, `best_valid` is set to 1 and `new_best` is asserted. On a tie, `best_lap_cs` is not updated and `new_best` is not asserted.
    - The prescaler is not reset. `total_time_cs` still takes that cycle's tick.
  - When `lap_count + 1 == LAPS` on a valid lap, go to FINISHED on the same edge.
  - `start` in RACING restarts the race: same clears as from IDLE, and the state stays RACING. `start` wins over a simultaneous `valid_lap`.
- State FINISHED:
  - `race_over` is 1. All timers and counters are frozen.
  - Further `lap_finished` activity is ignored.
  - `start` restarts the race as from IDLE and goes to RACING.
- `rst` has priority over everything, including mid-race, and returns to the reset state.

## Timing
- Inputs are registered upstream and used directly without synchronisers.
- `valid_lap` in cycle N: `lap_count`, `last_lap_cs`, `best_lap_cs`, `lap_time_cs=0`, `new_lap`, `new_best` and `race_over` (when applicable) all appear after edge N+1. This is a 1-cycle latency.
- `new_lap` and `new_best` are high for exactly one cycle.
- The finish zone must be left (`lap_finished` 0 for at least one cycle) before another lap can count. A long dwell counts as at most one lap.
- The first tick after `start` occurs CLK_HZ/100 cycles later.

## Test plan
Sim with CLK_HZ=1000 (tick every 10 cycles), LAPS=3.
- Reset, then `start`; hold 250 cycles -> `lap_time_cs`=25, `total_time_cs`=25, `lap_count`=0, `race_over`=0.
- Pulse `lap_finished` high 5 cycles with `checkpoints_passed`=0 -> no `new_lap`, `lap_count` stays 0, timers keep running.
- Valid laps at lap times 40, 30, 35 cs -> `last_lap_cs`=35, `best_lap_cs`=30, `new_best` pulsed on laps 1 and 2 only, `lap_count`=3, `race_over`=1, `total_time_cs`=105 and frozen afterwards.
- Hold `lap_finished`=1 and `checkpoints_passed`=1 for 50 cycles -> exactly one `new_lap` pulse.
- Tie: two laps of 20 cs -> second lap gives `new_best`=0 and `best_lap_cs`=20.
- `start` asserted in the same cycle as `valid_lap` mid-race -> all counters cleared, state RACING, no `new_lap`. `rst` mid-race -> all outputs 0, state IDLE.
